adc_fill_reader: RTL and testbench
==================================

Name: adc_fill_reader

Overview:
- Readout-side counterpart of the ADC acquisition path: pops one stored fill (header word, N data words, checksum word) from the 128-bit DDR3 read FIFO.
- Parses and validates the header and recomputes the XOR checksum.
- Serialises the fill into a 32-bit valid/ready stream towards the link/readout logic.
- Reports fill number, burst count, checksum mismatch and FIFO-starvation timeout.

Parameters:
- TIMEOUT_CYCLES, 65535, consecutive stalled cycles with FIFO empty mid-fill before abort (16-bit counter).
- MS_LANE_FIRST, 1, 1: emit bits [127:96] first; 0: emit bits [31:0] first.

Ports:
- clk  in  1  readout clock; all logic in this domain.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: read one fill; ignored unless in IDLE.
- abort  in  1  synchronous; return to IDLE next cycle and discard the held word.
- fifo_dout  in  128  first-word-fall-through read FIFO data.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  pop strobe; only asserted when fifo_empty=0.
- out_dat  out  32  stream data.
- out_valid  out  1  stream valid.
- out_last  out  1  final beat of the fill.
- out_ready  in  1  downstream accept.
- busy  out  1  state is not IDLE.
- fill_done  out  1  one-cycle pulse at end of fill, either normal or timeout.
- fill_num  out  24  from header, held until the next header.
- num_fill_bursts  out  21  from header, held.
- checksum_err  out  1  sticky per fill; cleared on start.
- timeout_err  out  1  sticky per fill; cleared on start.

Behaviour:
- Reset: all outputs 0; state IDLE; holding register invalid; checksum accumulator 0.
- Header word fields:
  - [127:104] fill_num
  - [103:81] burst_start_adr (unused here)
  - [80:60] num_fill_bursts
  - [59:58] fill_type
  - [57:42] channel_tag
  - [41:0] zero
- Checksum word: the checksum is in [31:0].
- Checksum definition: XOR of all four 32-bit lanes of the header and of every data word.
- States: IDLE → HDR → DATA → CSUM → DONE → IDLE.
  - IDLE: on start, clear the error flags and accumulator, go to HDR.
  - HDR: pop the header; latch fill_num and num_fill_bursts; load the burst down-counter. A count of 0 goes directly to CSUM after the header beats; otherwise go to DATA.
  - DATA: pop words; decrement the counter on each pop; after popping the last data word, go to CSUM.
  - CSUM: pop the checksum word; compare its [31:0] to the accumulator; set checksum_err on mismatch. The word is still forwarded as 4 beats, with out_last on its 4th beat.
  - DONE: pulse fill_done for one cycle, go to IDLE.
- Holding register and beat sequencing:
  - Each popped word is loaded into a 128-bit holding register and emitted as 4 beats, beat index 0..3, ordered per MS_LANE_FIRST.
  - A beat advances only when out_valid and out_ready are both 1.
  - out_dat, out_valid and out_last are stable while out_ready=0.
- Pop timing and throughput:
  - fifo_rd_en=1 when the FIFO is non-empty, more words remain in the fill, and either the holding register is invalid or beat 3 is being accepted this cycle.
  - With continuous out_ready=1 and a non-empty FIFO, there are no bubbles: one beat per cycle.
- Latency:
  - start at cycle 0 → fifo_rd_en at cycle 1 (FIFO non-empty) → first out_valid at cycle 2.
  - Total beats per fill = 4*(N+2).
- Timeout:
  - The counter increments each cycle in HDR, DATA or CSUM while a pop is needed and fifo_empty=1. It resets on each pop.
  - When it reaches TIMEOUT_CYCLES: set timeout_err, drop out_valid, pulse fill_done, go to IDLE. out_last is never asserted for an aborted fill.
- Arithmetic:
  - The burst counter is 21-bit, unsigned, and never wraps; decrement is only allowed when non-zero.
- Simultaneous events:
  - abort has priority over all else.
  - start while busy is ignored.
  - abort in IDLE has no effect.
  - abort or reset mid-fill leaves the remaining FIFO words unread; the upstream reset is responsible for flushing them.

Test Plan:
- Fill with N=2, XOR-consistent checksum, out_ready=1: exactly 16 beats, first beat = header[127:96], out_last on beat 16, fill_done once, checksum_err=0, fill_num/num_fill_bursts match the header.
- N=0 fill: 8 beats (header, checksum); no DATA state entered; checksum = XOR of the 4 header lanes.
- Corrupted checksum (bit 0 flipped), N=3: all 20 beats still emitted; checksum_err=1 after CSUM; cleared on the next start.
- out_ready toggled 1/0 every cycle, N=4: out_dat held while out_ready=0; beat order and count (24) unchanged; no word popped early.
- TIMEOUT_CYCLES=16, FIFO runs empty after the header: 17th empty cycle → timeout_err=1, fill_done pulse, out_last never seen, busy=0.
- abort after 5 accepted beats: out_valid=0 and busy=0 the next cycle. reset_n asserted mid-fill: all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/adc_fill_reader.sv
// -----------------------------------------------------------------------------
// adc_fill_reader
//
// Pops one stored fill (header word, N data words, checksum word) from a
// 128-bit first-word-fall-through read FIFO. It parses the header, recomputes
// the XOR checksum, and serialises every word as four 32-bit beats on a
// valid/ready stream.
//
// Parameters
//   TIMEOUT_CYCLES  consecutive starved cycles mid-fill before the fill is aborted
//   MS_LANE_FIRST   1: bits [127:96] go out first, 0: bits [31:0] go out first
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   start             one-cycle request to read one fill (only honoured in IDLE)
//   abort             synchronous abort back to IDLE, drops the held word
//   fifo_dout/empty   FWFT FIFO data and empty flag
//   fifo_rd_en        FIFO pop strobe
//   out_dat/valid/last/ready   32-bit output stream
//   busy              FSM not in IDLE
//   fill_done         one-cycle pulse at the end of a fill (normal or timeout)
//   fill_num, num_fill_bursts  header fields, held until the next header
//   checksum_err, timeout_err  sticky per fill, cleared on start
// -----------------------------------------------------------------------------
module adc_fill_reader #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter bit          MS_LANE_FIRST  = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] fifo_dout,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  output logic [31:0]  out_dat,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy,
  output logic         fill_done,
  output logic [23:0]  fill_num,
  output logic [20:0]  num_fill_bursts,
  output logic         checksum_err,
  output logic         timeout_err
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  // The state names the next word that still has to be popped; the holding
  // register drains the previous word in parallel.
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE} state_t;

  state_t        state;
  logic [127:0]  hold;
  logic          hold_valid;
  logic          hold_is_csum;
  logic [1:0]    beat;
  logic [20:0]   burst_cnt;
  logic [31:0]   acc;
  logic [15:0]   tmo_cnt;
  logic          csum_popped;

  logic          need_pop;
  logic          accept;
  logic          last_beat_accept;
  logic          pop;
  logic          tmo_hit;
  logic [31:0]   lane_xor;
  logic [1:0]    lane;

  // NOTE: every signal gets a default at the top of the always_comb so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    need_pop         = (state == S_HDR) || (state == S_DATA) ||
                       ((state == S_CSUM) && !csum_popped);
    accept           = hold_valid && out_ready;
    last_beat_accept = accept && (beat == 2'd3);
    // A new word may only replace the held one once its last beat is taken.
    pop              = need_pop && !fifo_empty && !abort &&
                       (!hold_valid || last_beat_accept);
    tmo_hit          = need_pop && fifo_empty && (tmo_cnt == TMO_LIMIT);
    lane_xor         = fifo_dout[127:96] ^ fifo_dout[95:64] ^
                       fifo_dout[63:32]  ^ fifo_dout[31:0];
    lane             = MS_LANE_FIRST ? ~beat : beat;
    out_dat          = hold[{lane, 5'd0} +: 32];
  end

  assign fifo_rd_en = pop;
  assign out_valid  = hold_valid;
  assign out_last   = hold_valid && hold_is_csum && (beat == 2'd3);
  assign busy       = (state != S_IDLE);

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      // NOTE: the wide holding register is reset on purpose: out_dat is a
      // direct view of it and must read zero out of reset.
      hold            <= '0;
      hold_valid      <= 1'b0;
      hold_is_csum    <= 1'b0;
      beat            <= 2'd0;
      burst_cnt       <= '0;
      acc             <= '0;
      tmo_cnt         <= '0;
      csum_popped     <= 1'b0;
      fill_done       <= 1'b0;
      fill_num        <= '0;
      num_fill_bursts <= '0;
      checksum_err    <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state      <= S_IDLE;
        hold_valid <= 1'b0;
        beat       <= 2'd0;
      end else begin
        // Holding register and beat sequencing.
        if (pop) begin
          hold         <= fifo_dout;
          hold_valid   <= 1'b1;
          hold_is_csum <= (state == S_CSUM);
          beat         <= 2'd0;
        end else if (accept) begin
          if (beat == 2'd3) hold_valid <= 1'b0;
          beat <= beat + 2'd1;
        end

        // Starvation counter: only runs while a pop is wanted but the FIFO is dry.
        if (pop || (state == S_IDLE)) tmo_cnt <= '0;
        else if (need_pop && fifo_empty) tmo_cnt <= tmo_cnt + 16'd1;

        case (state)
          S_IDLE: begin
            if (start) begin
              checksum_err <= 1'b0;
              timeout_err  <= 1'b0;
              acc          <= '0;
              csum_popped  <= 1'b0;
              state        <= S_HDR;
            end
          end
          S_HDR: begin
            if (pop) begin
              fill_num        <= fifo_dout[127:104];
              num_fill_bursts <= fifo_dout[80:60];
              burst_cnt       <= fifo_dout[80:60];
              acc             <= acc ^ lane_xor;
              state           <= (fifo_dout[80:60] == '0) ? S_CSUM : S_DATA;
            end
          end
          S_DATA: begin
            if (pop) begin
              acc <= acc ^ lane_xor;
              if (burst_cnt != '0) burst_cnt <= burst_cnt - 21'd1;
              if (burst_cnt <= 21'd1) state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (pop) begin
              csum_popped <= 1'b1;
              if (fifo_dout[31:0] != acc) checksum_err <= 1'b1;
            end else if (csum_popped && hold_is_csum && last_beat_accept) begin
              fill_done <= 1'b1;
              state     <= S_DONE;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase

        // Starvation abort overrides the normal sequencing; no out_last is sent.
        if (tmo_hit) begin
          timeout_err <= 1'b1;
          hold_valid  <= 1'b0;
          fill_done   <= 1'b1;
          state       <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_fill_reader.sv
// -----------------------------------------------------------------------------
// tb_adc_fill_reader
//
// Directed bench for adc_fill_reader. Each fill is written into a FIFO model;
// at the same time the beats it must produce go into a scoreboard queue. A
// monitor running on the falling edge pops that queue on every accepted beat.
// -----------------------------------------------------------------------------
module tb_adc_fill_reader;

  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] fifo_dout = '0;
  logic         fifo_empty = 1'b1;
  logic         fifo_rd_en;
  logic [31:0]  out_dat;
  logic         out_valid;
  logic         out_last;
  logic         out_ready = 1'b1;
  logic         busy;
  logic         fill_done;
  logic [23:0]  fill_num;
  logic [20:0]  num_fill_bursts;
  logic         checksum_err;
  logic         timeout_err;

  always #5 clk = ~clk;

  adc_fill_reader #(.TIMEOUT_CYCLES(TMO), .MS_LANE_FIRST(1'b1)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .fifo_dout       (fifo_dout),
    .fifo_empty      (fifo_empty),
    .fifo_rd_en      (fifo_rd_en),
    .out_dat         (out_dat),
    .out_valid       (out_valid),
    .out_last        (out_last),
    .out_ready       (out_ready),
    .busy            (busy),
    .fill_done       (fill_done),
    .fill_num        (fill_num),
    .num_fill_bursts (num_fill_bursts),
    .checksum_err    (checksum_err),
    .timeout_err     (timeout_err)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
  } beat_t;

  beat_t        exp_q[$];
  logic [127:0] fq[$];
  beat_t        mon_e;

  int n_tests = 0;
  int n_fail  = 0;
  int beats_acc, pops, done_cnt, last_cnt, empty_cyc;
  bit pop_req = 1'b0;
  bit ready_toggle = 1'b0;
  bit prev_stall = 1'b0;
  logic [33:0] prev_out = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fifo_refresh();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = fifo_empty ? '0 : fq[0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lanes_xor(input logic [127:0] w);
    return w[127:96] ^ w[95:64] ^ w[63:32] ^ w[31:0];
  endfunction

  function automatic logic [127:0] mk_hdr(input logic [23:0] fnum, input logic [22:0] adr,
                                          input logic [20:0] n, input logic [1:0] typ,
                                          input logic [15:0] tag);
    return {fnum, adr, n, typ, tag, 42'h0};
  endfunction

  // Queue one word into the FIFO model and its four expected beats (MS lane first).
  task automatic push_word(input logic [127:0] w, input bit is_csum, input bit emit);
    beat_t nb;
    fq.push_back(w);
    if (emit) begin
      for (int b = 0; b < 4; b++) begin
        nb.dat  = w[127 - 32*b -: 32];
        nb.last = is_csum && (b == 3);
        exp_q.push_back(nb);
      end
    end
    fifo_refresh();
  endtask

  task automatic load_fill(input logic [23:0] fnum, input logic [20:0] n,
                           input bit corrupt, input bit data_present);
    logic [127:0] h, w;
    logic [31:0]  acc;
    h   = mk_hdr(fnum, 23'h00_1A2B, n, 2'b10, 16'h5A5A);
    acc = lanes_xor(h);
    push_word(h, 1'b0, 1'b1);
    if (data_present) begin
      for (int i = 0; i < int'(n); i++) begin
        w = {fnum[7:0], 24'(i), 32'hCAFE_0000 + 32'(i),
             32'h0F0F_0F0F << i, 32'h8000_0001 ^ {fnum, 8'(i)}};
        acc = acc ^ lanes_xor(w);
        push_word(w, 1'b0, 1'b1);
      end
      // Upper 96 bits of the checksum word carry junk; only [31:0] counts.
      push_word({96'hA5A5_A5A5_5A5A_5A5A_F00D_F00D, acc ^ 32'(corrupt)}, 1'b1, 1'b1);
    end
  endtask

  // FIFO model: pops on the edge after the monitor saw fifo_rd_en.
  always @(posedge clk) begin
    #1;
    if (pop_req && (fq.size() > 0)) void'(fq.pop_front());
    fifo_refresh();
    out_ready = ready_toggle ? ~out_ready : 1'b1;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
      pop_req    = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", 128'({out_valid, out_last, out_dat}), 128'(prev_out));
      if (out_valid && out_ready) begin
        beats_acc++;
        if (out_last) last_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got dat=%h last=%b, none expected", out_dat, out_last);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat", 128'({out_last, out_dat}), 128'({mon_e.last, mon_e.dat}));
        end
      end
      if (fifo_rd_en) begin
        check("rd_nonempty", 128'(fifo_empty), 128'(0));
        check("rd_timing", 128'(beats_acc), 128'(pops * 4));
        pops++;
      end
      if (fill_done) done_cnt++;
      if (busy && fifo_empty) empty_cyc++;
      pop_req    = fifo_rd_en;
      prev_stall = out_valid && !out_ready;
      prev_out   = {1'b0, out_valid, out_last, out_dat};
    end
  end

  // Start pulse plus latency checks; returns at cycle 3 (+1 time unit).
  task automatic start_fill(input string tag);
    beats_acc = 0; pops = 0; done_cnt = 0; last_cnt = 0; empty_cyc = 0;
    start = 1'b1;
    @(negedge clk);
    check({tag, "_cyc0_rd"}, 128'({busy, fifo_rd_en}), 128'(2'b00));
    step();
    start = 1'b0;
    @(negedge clk);
    check({tag, "_cyc1"}, 128'({busy, fifo_rd_en, out_valid, checksum_err, timeout_err}),
          128'(5'b11000));
    step();
    @(negedge clk);
    check({tag, "_cyc2_valid"}, 128'(out_valid), 128'(1));
    step();
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 400 && done_cnt == 0; c++) step();
    check({tag, "_done_seen"}, 128'(done_cnt != 0), 128'(1));
    check({tag, "_busy_after"}, 128'(busy), 128'(0));
    repeat (3) step();
    check({tag, "_done_once"}, 128'(done_cnt), 128'(1));
  endtask

  task automatic post_checks(input string tag, input int beats, input int lasts,
                             input bit cerr, input bit terr,
                             input logic [23:0] fnum, input logic [20:0] nb);
    check({tag, "_beats"}, 128'(beats_acc), 128'(beats));
    check({tag, "_lasts"}, 128'(last_cnt), 128'(lasts));
    check({tag, "_exp_left"}, 128'(exp_q.size()), 128'(0));
    check({tag, "_errs"}, 128'({checksum_err, timeout_err}), 128'({cerr, terr}));
    check({tag, "_hdr"}, 128'({fill_num, num_fill_bursts}), 128'({fnum, nb}));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] h;
    repeat (3) step();
    @(negedge clk);
    check("reset_outputs",
          128'({fifo_rd_en, out_valid, out_last, busy, fill_done, checksum_err, timeout_err,
                out_dat, fill_num, num_fill_bursts}), 128'(0));
    step();
    reset_n = 1'b1;
    repeat (2) step();

    // N=2, good checksum, ready always high.
    load_fill(24'h00_0101, 21'd2, 1'b0, 1'b1);
    start_fill("n2");
    wait_done("n2");
    post_checks("n2", 16, 1, 1'b0, 1'b0, 24'h00_0101, 21'd2);

    // N=0: header then checksum; checksum = XOR of header lanes, worked by hand:
    // lanes 00000500 ^ 00000000 ^ 06FBBC00 ^ 00000000 = 06FBB900.
    h = mk_hdr(24'h00_0005, 23'h0, 21'd0, 2'b01, 16'hBEEF);
    push_word(h, 1'b0, 1'b1);
    push_word({96'h0, 32'h06FB_B900}, 1'b1, 1'b1);
    start_fill("n0");
    wait_done("n0");
    post_checks("n0", 8, 1, 1'b0, 1'b0, 24'h00_0005, 21'd0);

    // N=3 with checksum bit 0 flipped.
    load_fill(24'h12_3456, 21'd3, 1'b1, 1'b1);
    start_fill("bad");
    wait_done("bad");
    post_checks("bad", 20, 1, 1'b1, 1'b0, 24'h12_3456, 21'd3);

    // N=4 with out_ready toggling; also shows checksum_err cleared on start.
    ready_toggle = 1'b1;
    load_fill(24'h00_0444, 21'd4, 1'b0, 1'b1);
    start_fill("tog");
    wait_done("tog");
    post_checks("tog", 24, 1, 1'b0, 1'b0, 24'h00_0444, 21'd4);
    ready_toggle = 1'b0;
    repeat (2) step();

    // Starvation: only the header is ever available.
    load_fill(24'h0A_0A0A, 21'd5, 1'b0, 1'b0);
    start_fill("tmo");
    wait_done("tmo");
    post_checks("tmo", 4, 0, 1'b0, 1'b1, 24'h0A_0A0A, 21'd5);
    check("tmo_empty_cycles", 128'(empty_cyc), 128'(17));
    fq.delete();
    fifo_refresh();

    // Abort after 5 accepted beats.
    load_fill(24'h00_ABCD, 21'd3, 1'b0, 1'b1);
    start_fill("abt");
    for (int c = 0; c < 50 && beats_acc < 5; c++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    check("abt_idle", 128'({out_valid, busy, fifo_rd_en, out_last}), 128'(0));
    check("abt_no_done", 128'({done_cnt, last_cnt}), 128'(0));
    exp_q.delete();
    fq.delete();
    fifo_refresh();
    step();

    // Asynchronous reset mid-fill.
    load_fill(24'h00_7777, 21'd2, 1'b0, 1'b1);
    start_fill("rst");
    repeat (3) step();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async",
          128'({fifo_rd_en, out_valid, out_last, busy, fill_done, checksum_err, timeout_err,
                out_dat, fill_num, num_fill_bursts}), 128'(0));
    exp_q.delete();
    fq.delete();
    fifo_refresh();
    step();
    reset_n = 1'b1;
    repeat (2) step();

    // Recovery after reset.
    load_fill(24'h00_0001, 21'd1, 1'b0, 1'b1);
    start_fill("rec");
    wait_done("rec");
    post_checks("rec", 12, 1, 1'b0, 1'b0, 24'h00_0001, 21'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
